score_keeper: RTL and testbench

- Consumes the composite ball video and the paddle video, together with the Vga timing strobes.
- Detects paddle hits and misses once per frame, and keeps BCD rally (hit) and miss counters.
- Renders the two-digit miss count as a 1-bit overlay, which the top level ORs into the Vga video input.
- Also emits one-cycle hit/miss event pulses for downstream use (sound, serve logic).

---
 rtl/score_keeper_if.sv | 25 ++
 rtl/score_keeper.sv | 165 ++++++++++++++++
 tb/tb_score_keeper.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/score_keeper_if.sv
// Video timing / pixel inputs and score outputs shared between the
// video front end (master) and score_keeper (slave).
interface score_keeper_if;
  logic       i_HReset;
  logic       i_VReset;
  logic       i_HBlank;
  logic       i_VBlank;
  logic       i_Ball_Video;
  logic       i_Paddle_Video;
  logic       o_Hit;
  logic       o_Miss;
  logic [7:0] o_Rally;
  logic [7:0] o_Misses;
  logic       o_Video;

  modport master (
    output i_HReset, i_VReset, i_HBlank, i_VBlank, i_Ball_Video, i_Paddle_Video,
    input  o_Hit, o_Miss, o_Rally, o_Misses, o_Video
  );

  modport slave (
    input  i_HReset, i_VReset, i_HBlank, i_VBlank, i_Ball_Video, i_Paddle_Video,
    output o_Hit, o_Miss, o_Rally, o_Misses, o_Video
  );
endinterface

// File: rtl/score_keeper.sv
// Per-frame hit/miss detection with BCD rally/miss counters.
// Define SCORE_DISPLAY_EN to render the miss count as a two-glyph overlay on o_Video.
module score_keeper #(
  parameter int p_MISS_X     = 8,
  parameter int p_HOLDOFF    = 30,
  parameter int p_DIGIT_X    = 300,
  parameter int p_DIGIT_Y    = 16,
  parameter int p_SCALE_LOG2 = 2
) (
  input  logic          i_Clk,
  input  logic          i_Rst_L,
  score_keeper_if.slave bus
);

  localparam int HW = (p_HOLDOFF < 1) ? 1 : $clog2(p_HOLDOFF + 1);

  typedef enum logic {ST_ACTIVE, ST_COMMIT} state_t;

  state_t          state_q;
  logic [9:0]      x_q, x_d;
  logic            vblank_prev_q;
  logic            armed_q;
  logic            hit_flag_q, miss_flag_q;
  logic [HW-1:0]   holdoff_q;
  logic            hit_q, miss_q;
  logic [7:0]      rally_q, misses_q;
  logic [7:0]      rally_d, misses_d;
  logic            hit_det, miss_det, vrise;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)          return v;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                     return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    x_d      = bus.i_HReset ? 10'd0 : ((x_q == 10'h3FF) ? x_q : x_q + 10'd1);
    hit_det  = armed_q && !bus.i_HBlank && !bus.i_VBlank &&
               bus.i_Ball_Video && bus.i_Paddle_Video;
    miss_det = armed_q && !bus.i_HBlank && !bus.i_VBlank &&
               bus.i_Ball_Video && (x_q < 10'(p_MISS_X));
    vrise    = bus.i_VBlank && !vblank_prev_q;
    rally_d  = bcd_inc(rally_q);
    misses_d = bcd_inc(misses_q);
  end

  // armed_q stays low until a frame start is seen, so a reset mid-frame
  // suppresses the partial frame's commit.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q       <= ST_ACTIVE;
      x_q           <= '0;
      vblank_prev_q <= 1'b1;
      armed_q       <= 1'b0;
      hit_flag_q    <= 1'b0;
      miss_flag_q   <= 1'b0;
      holdoff_q     <= '0;
      hit_q         <= 1'b0;
      miss_q        <= 1'b0;
      rally_q       <= '0;
      misses_q      <= '0;
    end else begin
      x_q           <= x_d;
      vblank_prev_q <= bus.i_VBlank;
      if (bus.i_VReset) armed_q <= 1'b1;
      case (state_q)
        ST_ACTIVE: begin
          hit_flag_q  <= hit_flag_q  | hit_det;
          miss_flag_q <= miss_flag_q | miss_det;
          if (vrise && armed_q) begin
            state_q <= ST_COMMIT;
            if (hit_flag_q) begin
              hit_q   <= 1'b1;
              rally_q <= rally_d;
              if (holdoff_q != '0) holdoff_q <= holdoff_q - 1'b1;
            end else if (miss_flag_q && holdoff_q == '0) begin
              miss_q    <= 1'b1;
              misses_q  <= misses_d;
              rally_q   <= '0;
              holdoff_q <= HW'(p_HOLDOFF);
            end else if (holdoff_q != '0) begin
              holdoff_q <= holdoff_q - 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          hit_q       <= 1'b0;
          miss_q      <= 1'b0;
          hit_flag_q  <= 1'b0;
          miss_flag_q <= 1'b0;
          state_q     <= ST_ACTIVE;
        end
        default: state_q <= ST_ACTIVE;
      endcase
    end
  end

  assign bus.o_Hit    = hit_q;
  assign bus.o_Miss   = miss_q;
  assign bus.o_Rally  = rally_q;
  assign bus.o_Misses = misses_q;

`ifdef SCORE_DISPLAY_EN
  localparam int BOX_W = 7 << p_SCALE_LOG2;
  localparam int BOX_H = 5 << p_SCALE_LOG2;

  logic [9:0]  y_q, y_d;
  logic [9:0]  dx, dy;
  logic [2:0]  cx, cy;
  logic [1:0]  col;
  logic [3:0]  digit, idx;
  logic [14:0] glyph;
  logic        in_box, video_d, video_q;

  // 3x5 bitmap, row 0 in [14:12], leftmost column is the MSB of each row
  function automatic logic [14:0] glyph_rom(input logic [3:0] d);
    case (d)
      4'd0:    return 15'b111_101_101_101_111;
      4'd1:    return 15'b110_010_010_010_111;
      4'd2:    return 15'b111_001_111_100_111;
      4'd3:    return 15'b111_001_111_001_111;
      4'd4:    return 15'b101_101_111_001_001;
      4'd5:    return 15'b111_100_111_001_111;
      4'd6:    return 15'b111_100_111_101_111;
      4'd7:    return 15'b111_001_001_001_001;
      4'd8:    return 15'b111_101_111_101_111;
      4'd9:    return 15'b111_101_111_001_111;
      default: return 15'b0;
    endcase
  endfunction

  always_comb begin
    y_d = y_q;
    if (bus.i_VReset)                       y_d = 10'd0;
    else if (bus.i_HReset && y_q != 10'h3FF) y_d = y_q + 10'd1;
    dx      = x_q - 10'(p_DIGIT_X);
    dy      = y_q - 10'(p_DIGIT_Y);
    in_box  = ({1'b0, x_q} >= 11'(p_DIGIT_X)) && ({1'b0, x_q} < 11'(p_DIGIT_X + BOX_W)) &&
              ({1'b0, y_q} >= 11'(p_DIGIT_Y)) && ({1'b0, y_q} < 11'(p_DIGIT_Y + BOX_H));
    cx      = 3'(dx >> p_SCALE_LOG2);
    cy      = 3'(dy >> p_SCALE_LOG2);
    col     = cx[1:0];
    digit   = cx[2] ? misses_q[3:0] : misses_q[7:4];
    glyph   = glyph_rom(digit);
    idx     = ({1'b0, cy} * 4'd3) + {2'b00, col};
    video_d = in_box && (cx != 3'd3) && glyph[4'd14 - idx] &&
              !bus.i_HBlank && !bus.i_VBlank;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      y_q     <= '0;
      video_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      video_q <= video_d;
    end
  end

  assign bus.o_Video = video_q;
`else
  assign bus.o_Video = 1'b0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Directed-vector bench for score_keeper: frames are synthesized line by line
// and the counters/pulses are compared against hand-computed values.
module tb_score_keeper;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0, n_fail = 0;
  int   hit_cnt = 0, miss_cnt = 0, both_cnt = 0, vid_cnt = 0;
  int   cap_x[3] = '{-1, -1, -1};
  int   cap_y[3] = '{-1, -1, -1};
  logic cap_v[3];

  score_keeper_if sk_if();

  score_keeper dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .bus     (sk_if.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (sk_if.o_Hit)                 hit_cnt++;
      if (sk_if.o_Miss)                miss_cnt++;
      if (sk_if.o_Hit && sk_if.o_Miss) both_cnt++;
      if (sk_if.o_Video)               vid_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit hr, input bit vr, input bit hb, input bit vb,
                       input bit ball, input bit pad);
    sk_if.i_HReset       = hr;
    sk_if.i_VReset       = vr;
    sk_if.i_HBlank       = hb;
    sk_if.i_VBlank       = vb;
    sk_if.i_Ball_Video   = ball;
    sk_if.i_Paddle_Video = pad;
  endtask

  // One frame: per line an HReset/blank cycle then `width` active pixels
  // (pixel j sits at x=j, line l at y=l), followed by six vblank cycles.
  task automatic frame(input int lines, input int width, input int bx, input int by,
                       input bit ball, input bit pad, input int rst_line);
    for (int l = 0; l < lines; l++) begin
      if (l == rst_line) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      drive(1'b1, l == 0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      for (int j = 0; j < width; j++) begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, ball && l == by && j == bx, pad && l == by && j == bx);
        step();
        for (int k = 0; k < 3; k++)
          if (l == cap_y[k] && j == cap_x[k]) cap_v[k] = sk_if.o_Video;
      end
    end
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
    end
  endtask

  task automatic short_frame(input int bx, input bit ball, input bit pad);
    frame(2, 24, bx, 1, ball, pad, -1);
  endtask

  initial begin
    int h0, m0;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) step();
    chk("reset_rally",  sk_if.o_Rally,  8'h00);
    chk("reset_misses", sk_if.o_Misses, 8'h00);
    chk("reset_hit",    sk_if.o_Hit,    1'b0);
    chk("reset_miss",   sk_if.o_Miss,   1'b0);
    chk("reset_video",  sk_if.o_Video,  1'b0);

    // release inside vblank: no commit on that vblank, nor on an empty frame
    rst_n = 1'b1;
    repeat (4) step();
    frame(2, 24, 0, 0, 1'b0, 1'b0, -1);
    chk("rel_vblank_pulses", hit_cnt + miss_cnt, 0);
    chk("rel_vblank_rally",  sk_if.o_Rally, 8'h00);

    // hit in line 0, reset during line 1: the partial frame must not commit
    frame(3, 24, 20, 0, 1'b1, 1'b1, 1);
    chk("midrst_hit",   hit_cnt, 0);
    chk("midrst_rally", sk_if.o_Rally, 8'h00);

    h0 = hit_cnt; m0 = miss_cnt;
    frame(202, 24, 20, 200, 1'b1, 1'b1, -1);
    chk("hit1_pulse", hit_cnt - h0, 1);
    chk("hit1_miss",  miss_cnt - m0, 0);
    chk("hit1_rally", sk_if.o_Rally, 8'h01);

    repeat (8) short_frame(20, 1'b1, 1'b1);
    chk("rally_09", sk_if.o_Rally, 8'h09);
    short_frame(20, 1'b1, 1'b1);
    chk("rally_carry", sk_if.o_Rally, 8'h10);

    h0 = hit_cnt; m0 = miss_cnt;
    short_frame(3, 1'b1, 1'b0);
    chk("miss1_pulse",  miss_cnt - m0, 1);
    chk("miss1_hit",    hit_cnt - h0, 0);
    chk("miss1_misses", sk_if.o_Misses, 8'h01);
    chk("miss1_rally",  sk_if.o_Rally, 8'h00);

    m0 = miss_cnt;
    repeat (30) short_frame(3, 1'b1, 1'b0);
    chk("holdoff_pulses", miss_cnt - m0, 0);
    chk("holdoff_misses", sk_if.o_Misses, 8'h01);
    short_frame(3, 1'b1, 1'b0);
    chk("miss31_pulse",  miss_cnt - m0, 1);
    chk("miss31_misses", sk_if.o_Misses, 8'h02);

    // let holdoff drain so the same-frame miss would otherwise be taken
    repeat (30) short_frame(0, 1'b0, 1'b0);
    h0 = hit_cnt; m0 = miss_cnt;
    short_frame(3, 1'b1, 1'b1);
    chk("both_hit",    hit_cnt - h0, 1);
    chk("both_miss",   miss_cnt - m0, 0);
    chk("both_misses", sk_if.o_Misses, 8'h02);
    chk("both_rally",  sk_if.o_Rally, 8'h01);
    short_frame(3, 1'b1, 1'b0);
    chk("miss3_misses", sk_if.o_Misses, 8'h03);
    chk("miss3_rally",  sk_if.o_Rally, 8'h00);

    h0 = hit_cnt;
    repeat (99) short_frame(20, 1'b1, 1'b1);
    chk("rally_99",   sk_if.o_Rally, 8'h99);
    chk("hits_99",    hit_cnt - h0, 99);
    short_frame(20, 1'b1, 1'b1);
    chk("rally_sat",  sk_if.o_Rally, 8'h99);
    chk("sat_pulse",  hit_cnt - h0, 100);

`ifdef SCORE_DISPLAY_EN
    repeat (7) begin
      repeat (30) short_frame(0, 1'b0, 1'b0);
      short_frame(3, 1'b1, 1'b0);
    end
    chk("misses_10", sk_if.o_Misses, 8'h10);
    cap_x = '{301, 313, 317};
    cap_y = '{17, 16, 17};
    frame(40, 320, 0, 0, 1'b0, 1'b0, -1);
    chk("vid_tens_cell00", cap_v[0], 1'b1);
    chk("vid_gap_cell3",   cap_v[1], 1'b0);
    chk("vid_ones_cell40", cap_v[2], 1'b1);
`else
    chk("video_off", vid_cnt, 0);
`endif
    chk("never_both", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
